downcounter_timer: RTL

DOWNCOUNTER_TIMER -- requirements
Module: downcounter_timer

---
 rtl/downcounter_timer.sv | 117 +++++++++++
 1 files changed

// File: rtl/downcounter_timer.sv
// Loadable down-counter timer: a prescaler divides clk by CLK_DIV into count
// ticks; q counts down to zero, then either stops in DONE or auto-reloads.
module downcounter_timer #(
  parameter int CLK_DIV = 100_000_000,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [W-1:0] q,
  output logic         running,
  output logic         tick,
  output logic         done
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_q, w_q_nxt;
  logic [W-1:0]  r_reload, w_reload_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_tick, w_tick_nxt;
  logic          r_done, w_done_nxt;
  logic          w_last;

  // q <= 1 also catches a stray zero so the count can never wrap.
  assign w_last = (r_q <= W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_presc  <= '0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_presc  <= w_presc_nxt;
      r_tick   <= w_tick_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    if (load) begin
      w_state_nxt  = S_IDLE;
      w_q_nxt      = load_val;
      w_reload_nxt = load_val;
      w_presc_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_presc_nxt = '0;
          if (start && (r_q != '0)) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          // Pause freezes the prescaler and swallows a tick due on this edge.
          if (pause) begin
            w_state_nxt = S_PAUSE;
          end else if (r_presc == PRE_MAX) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
            if (w_last) begin
              w_done_nxt = 1'b1;
              if (auto_reload && (r_reload != '0)) begin
                w_q_nxt = r_reload;
              end else begin
                w_q_nxt     = '0;
                w_state_nxt = S_DONE;
              end
            end else begin
              w_q_nxt = r_q - 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start && !pause) w_state_nxt = S_RUN;
        end
        S_DONE: begin
          w_q_nxt     = '0;
          w_presc_nxt = '0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign q       = r_q;
  assign running = (r_state == S_RUN);
  assign tick    = r_tick;
  assign done    = r_done;

endmodule
